// File: rtl/i2s_transmitter.sv
// i2s_transmitter: standard I2S (Philips) serializer with a one-pair holding register.
// Ports: clk/reset (sync, active-high); i_left_data/i_right_data/i_vld in, o_rdy out
// (pair accepted on i_vld && o_rdy); o_sck/o_ws/o_sd I2S bus; o_frame_start and
// o_underrun pulse for one clk at each frame load.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_HALF = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_left_data,
  input  logic [DATA_WIDTH-1:0] i_right_data,
  input  logic                  i_vld,
  output logic                  o_rdy,
  output logic                  o_sck,
  output logic                  o_ws,
  output logic                  o_sd,
  output logic                  o_frame_start,
  output logic                  o_underrun
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(CLK_HALF + 1);
  localparam int KW = $clog2(2 * W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HALF - 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * W - 1);
  localparam logic [KW-1:0] WS_LO = KW'(W - 1);
  localparam logic [KW-1:0] WS_HI = KW'(2 * W - 2);
  logic [CW-1:0]  r_cnt;
  logic           r_sck;
  logic [KW-1:0]  r_k;
  logic           r_ws;
  logic [2*W-1:0] r_sr;
  logic           r_hold_full;
  logic [W-1:0]   r_hold_l;
  logic [W-1:0]   r_hold_r;
  logic           r_frame_start;
  logic           r_underrun;
  logic           w_tick;
  logic           w_fall;
  logic           w_load;
  logic           w_accept;
  logic           w_ws_next;
  logic [KW-1:0]  w_k_next;
  // Everything on the bus moves on sck falling events so the receiver sees stable
  // data at every sck rising edge; ws is decoded from the slot being entered, which
  // makes it lead each slot's MSB by one sck period.
  always_comb begin
    w_tick    = r_cnt == CNT_LAST;
    w_fall    = w_tick & r_sck;
    w_load    = w_fall & (r_k == K_LAST);
    w_k_next  = (r_k == K_LAST) ? '0 : r_k + KW'(1);
    w_ws_next = (w_k_next >= WS_LO) & (w_k_next <= WS_HI);
    w_accept  = i_vld & ~r_hold_full;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_sck         <= 1'b0;
      r_k           <= K_LAST;
      r_ws          <= 1'b0;
      r_sr          <= '0;
      r_hold_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_cnt         <= w_tick ? '0 : r_cnt + CW'(1);
      r_sck         <= w_tick ? ~r_sck : r_sck;
      r_frame_start <= w_load;
      // an accept in the load clk arrives too late: this frame goes out as zeros
      r_underrun    <= w_load & ~r_hold_full;
      if (w_fall) begin
        r_k  <= w_k_next;
        r_ws <= w_ws_next;
        r_sr <= w_load ? (r_hold_full ? {r_hold_l, r_hold_r} : '0) : {r_sr[2*W-2:0], 1'b0};
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_l    <= i_left_data;
        r_hold_r    <= i_right_data;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end
  assign o_rdy         = ~r_hold_full;
  assign o_sck         = r_sck;
  assign o_ws          = r_ws;
  assign o_sd          = r_sr[2*W-1];
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: vector table, corner sequences and a randomized run against a frame-level model.
module tb_i2s_transmitter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] l1, r1;
  logic v1, rdy1, sck1, ws1, sd1, fs1, ur1;
  logic [23:0] l2, r2;
  logic v2, rdy2, sck2, ws2, sd2, fs2, ur2;
  int cyc, total, passed;
  typedef struct {
    int c;
    logic [5:0] v;
  } vec_t;
  vec_t tbl[11];
  logic [31:0] q[$];
  logic [31:0] word, exp_word;
  int idx, nb, urc, bad, sdbad, wslow, togbad, last_fs, stray, rdybad, wsbad, bitn, nfr;
  logic [15:0] inc;
  bit prev, on, acc, mode;

  always #5 clk = ~clk;

  i2s_transmitter #(.DATA_WIDTH(16), .CLK_HALF(2)) u1 (
    .clk(clk), .reset(reset), .i_left_data(l1), .i_right_data(r1), .i_vld(v1),
    .o_rdy(rdy1), .o_sck(sck1), .o_ws(ws1), .o_sd(sd1), .o_frame_start(fs1), .o_underrun(ur1));

  i2s_transmitter #(.DATA_WIDTH(24), .CLK_HALF(1)) u2 (
    .clk(clk), .reset(reset), .i_left_data(l2), .i_right_data(r2), .i_vld(v2),
    .o_rdy(rdy2), .o_sck(sck2), .o_ws(ws2), .o_sd(sd2), .o_frame_start(fs2), .o_underrun(ur2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    v1 = 1'b0;
    v2 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    cyc = 0;
    l1 = '0; r1 = '0; l2 = '0; r2 = '0; v1 = 1'b0; v2 = 1'b0;
    // {sck, ws, sd, rdy, frame_start, underrun} after clk n following reset release
    tbl[0]  = '{1,   6'b000000};
    tbl[1]  = '{2,   6'b100000};
    tbl[2]  = '{4,   6'b001110};
    tbl[3]  = '{5,   6'b001100};
    tbl[4]  = '{6,   6'b101100};
    tbl[5]  = '{8,   6'b000100};
    tbl[6]  = '{63,  6'b101100};
    tbl[7]  = '{64,  6'b011100};
    tbl[8]  = '{68,  6'b010100};
    tbl[9]  = '{128, 6'b001100};
    tbl[10] = '{132, 6'b000111};

    // pair loaded before the first falling event
    do_reset();
    chk("reset_state", {sck1, ws1, sd1, rdy1, fs1, ur1}, 6'b000100);
    l1 = 16'hA5C3; r1 = 16'h0F01; v1 = 1'b1;
    idx = 0; word = '0; nb = 0; urc = 0; prev = 1'b0;
    for (int n = 1; n <= 132; n++) begin
      step();
      v1 = 1'b0;
      if (idx < 11 && tbl[idx].c == cyc) begin
        chk($sformatf("vec@%0d", cyc), {sck1, ws1, sd1, rdy1, fs1, ur1}, tbl[idx].v);
        idx++;
      end
      if (!prev && sck1 && cyc >= 4) begin
        word = {word[30:0], sd1};
        nb++;
      end
      prev = sck1;
      if (cyc < 132 && ur1) urc++;
    end
    chk("tbl_done", idx, 11);
    chk("frame_bits", word, 32'hA5C30F01);
    chk("frame_nbits", nb, 32);
    chk("no_underrun", urc, 0);

    // idle: underrun frames every 128 clk, data stays zero
    do_reset();
    bad = 0; sdbad = 0;
    for (int n = 1; n <= 261; n++) begin
      step();
      if (cyc == 4 || cyc == 132 || cyc == 260) chk($sformatf("idle_pulse@%0d", cyc), {fs1, ur1}, 2'b11);
      else if (fs1 || ur1) bad++;
      if (sd1) sdbad++;
    end
    chk("idle_no_stray", bad, 0);
    chk("idle_sd_zero", sdbad, 0);

    // first accept lands in the load clk
    do_reset();
    repeat (3) step();
    l1 = 16'h8001; r1 = 16'h7FFF; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("late_acc@4", {fs1, ur1, rdy1, sd1}, 4'b1100);
    while (cyc < 132) step();
    chk("late_acc@132", {fs1, ur1, rdy1, sd1}, 4'b1011);

    // reset mid-frame with a pair waiting in holding
    do_reset();
    l1 = 16'h1234; r1 = 16'h5678; v1 = 1'b1;
    step();
    v1 = 1'b0;
    while (cyc < 4) step();
    l1 = 16'hFFFF; r1 = 16'hFFFF; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("held_rdy", rdy1, 1'b0);
    while (cyc < 44) step();
    reset = 1'b1;
    step();
    chk("mid_reset", {sck1, ws1, sd1, rdy1, fs1, ur1}, 6'b000100);
    reset = 1'b0;
    cyc = 0;
    sdbad = 0;
    for (int n = 1; n <= 132; n++) begin
      step();
      if (cyc == 4) chk("post_rst_load", {fs1, ur1}, 2'b11);
      if (sd1) sdbad++;
    end
    chk("held_discarded", sdbad, 0);

    // 24-bit, CLK_HALF=1 instance
    do_reset();
    l2 = 24'h800001; r2 = 24'h000001; v2 = 1'b1;
    step();
    v2 = 1'b0;
    chk("u2@1", {sck2, fs2}, 2'b10);
    step();
    chk("u2@2", {sck2, fs2, ur2, sd2, ws2}, 5'b01010);
    wslow = 1; togbad = 0; prev = sck2;
    while (cyc < 98) begin
      step();
      if (sck2 == prev) togbad++;
      prev = sck2;
      if (cyc <= 97 && !ws2) wslow++;
      if (cyc == 48) chk("u2_left_lsb", {ws2, sd2}, 2'b11);
      if (cyc == 50) chk("u2_right_msb", {ws2, sd2}, 2'b10);
      if (cyc == 95) chk("u2_ws_hi", ws2, 1'b1);
      if (cyc == 96) chk("u2_ws_fall", {ws2, sd2}, 2'b01);
    end
    chk("u2_sck_toggle", togbad, 0);
    chk("u2_ws_low_clks", wslow, 48);
    chk("u2_frame2", {fs2, ur2}, 2'b11);

    // randomized then continuous traffic against a frame-level model
    do_reset();
    q.delete();
    last_fs = 0; stray = 0; rdybad = 0; wsbad = 0; bitn = 0; nfr = 0;
    on = 1'b0; prev = 1'b0; inc = 16'd1; word = '0; exp_word = '0;
    for (int n = 1; n <= 5200; n++) begin
      mode = n > 2600;
      if (mode) begin
        v1 = 1'b1;
        l1 = inc;
        r1 = inc ^ 16'hC3C3;
      end else begin
        v1 = $urandom_range(0, 199) == 0;
        l1 = 16'($urandom);
        r1 = 16'($urandom);
      end
      acc = v1 && rdy1;
      step();
      if (fs1) begin
        if (last_fs != 0) chk("frame_len", cyc - last_fs, 128);
        last_fs = cyc;
        chk($sformatf("underrun@%0d", cyc), ur1, q.size() == 0);
        exp_word = (q.size() == 0) ? 32'h0 : q.pop_front();
        bitn = 0; word = '0; wsbad = 0; on = 1'b1;
      end else if (ur1) stray++;
      if (acc) begin
        q.push_back({l1, r1});
        if (mode) inc++;
      end
      if (rdy1 !== (q.size() == 0)) rdybad++;
      if (on && !prev && sck1) begin
        if (ws1 !== (bitn >= 15 && bitn <= 30)) wsbad++;
        word = {word[30:0], sd1};
        bitn++;
        if (bitn == 32) begin
          chk($sformatf("frame_data@%0d", cyc), word, exp_word);
          chk("frame_ws", wsbad, 0);
          nfr++;
          on = 1'b0;
        end
      end
      prev = sck1;
    end
    v1 = 1'b0;
    chk("rand_stray_ur", stray, 0);
    chk("rand_rdy", rdybad, 0);
    chk("rand_frames", nfr, 40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
